// File: rtl/rr_arbiter_n_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The rotate helpers work on a fixed-width container and take the live
// vector length, so the modulo-N wrap is correct for any N, not only
// powers of two.
package rr_arb_pkg;

    // Widest requester vector the helpers can handle.
    localparam int RR_MAXN = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } rr_state_e;

    // Rotate right by sh within the low n bits: result[i] = v[(i+sh) mod n].
    function automatic logic [RR_MAXN-1:0] rot_r(input logic [RR_MAXN-1:0] v,
                                                 input int sh, input int n);
        logic [RR_MAXN-1:0] r;
        r = '0;
        for (int i = 0; i < RR_MAXN; i++) begin
            if (i < n) r[i] = v[(i + sh) % n];
        end
        return r;
    endfunction

    // Inverse of rot_r: result[(i+sh) mod n] = v[i].
    function automatic logic [RR_MAXN-1:0] rot_l(input logic [RR_MAXN-1:0] v,
                                                 input int sh, input int n);
        logic [RR_MAXN-1:0] r;
        r = '0;
        for (int i = 0; i < RR_MAXN; i++) begin
            if (i < n) r[(i + sh) % n] = v[i];
        end
        return r;
    endfunction

    // One-hot (or zero) vector to bit index; zero maps to 0.
    function automatic int oh_to_idx(input logic [RR_MAXN-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < RR_MAXN; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// master drives requests, slave (the arbiter) drives the grant outputs.
interface rr_arbiter_n_if #(
    parameter int N = 4
) ();
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_vld;
    logic           gnt_new;

    modport master (output req, input gnt, gnt_id, gnt_vld, gnt_new);
    modport slave  (input req, output gnt, gnt_id, gnt_vld, gnt_new);
endinterface

// File: rtl/rr_arbiter_n_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// ignoring any bit set in excl_i. The vector is rotated so ptr_i lands on
// bit 0, the lowest set bit is isolated, then rotated back.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int  N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    input  logic [N-1:0]   excl_i,
    output logic [N-1:0]   win_o,
    output logic           found_o
);

    logic [RR_MAXN-1:0] cand;
    logic [RR_MAXN-1:0] rot;
    logic [RR_MAXN-1:0] first;
    logic [RR_MAXN-1:0] back;

    // Rotate, isolate lowest set bit, rotate back.
    always_comb begin
        cand    = RR_MAXN'(req_i & ~excl_i);
        rot     = rot_r(cand, int'(ptr_i), N);
        first   = rot & (~rot + RR_MAXN'(1));
        back    = rot_l(first, int'(ptr_i), N);
        win_o   = back[N-1:0];
        found_o = |cand;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters with registered one-hot grants.
// Optional macro RR_ARB_LOCK_EN: when defined an owner may hold the grant
// for up to MAX_HOLD consecutive cycles under contention; when undefined
// the hold counter is absent and a contended owner rotates every cycle.
//
//  state   | meaning
//  --------+-----------------------------------------------
//  ST_IDLE | no owner, gnt all-zero
//  ST_OWN  | gnt_q holds the current owner (one-hot)
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int  N        = 4,
    parameter int  MAX_HOLD = 4,
    localparam int IDW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_n_if.slave bus
);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_OWN  = ST_OWN;

    logic [0:0]     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           new_q, new_d;

    logic [N-1:0]   excl;
    logic [N-1:0]   win;
    logic           found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] next_ptr;
    logic           owner_req;
    logic           others;
    logic           at_limit;
    logic           take;

    assign owner_req = |(bus.req & gnt_q);
    assign others    = |(bus.req & ~gnt_q);

    // The current owner is excluded from release and forced-rotation searches.
    assign excl = ((state_q == S_OWN) && (!owner_req || at_limit)) ? gnt_q : '0;

    rr_pick #(.N(N)) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .excl_i  (excl),
        .win_o   (win),
        .found_o (found)
    );

    assign win_idx  = IDW'(oh_to_idx(RR_MAXN'(win)));
    assign next_ptr = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);

`ifdef RR_ARB_LOCK_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hcnt_q;

    assign at_limit = (hcnt_q == HW'(MAX_HOLD));

    // Hold counter: 1 on a new grant, counts while the owner keeps
    // requesting, saturates at MAX_HOLD, clears when going idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
        end else if (take) begin
            hcnt_q <= HW'(1);
        end else if (state_d == S_IDLE) begin
            hcnt_q <= '0;
        end else if ((state_q == S_OWN) && owner_req && !at_limit) begin
            hcnt_q <= hcnt_q + HW'(1);
        end
    end
`else
    // Without the lock window every contended owner is already at its limit.
    assign at_limit = 1'b1;
`endif

    // Next-state decode: decide whether to take the picker's winner.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        new_d   = 1'b0;
        take    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found) take = 1'b1;
            end
            S_OWN: begin
                if (!owner_req) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                    end
                end else if (at_limit && others) begin
                    take = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase

        if (take) begin
            state_d = S_OWN;
            gnt_d   = win;
            id_d    = win_idx;
            ptr_d   = next_ptr;
            new_d   = 1'b1;
        end
    end

    // State, grant and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            new_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            new_q   <= new_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_id  = id_q;
    assign bus.gnt_vld = |gnt_q;
    assign bus.gnt_new = new_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n with N=4, MAX_HOLD=4. Expected grants
// follow the lock build when RR_ARB_LOCK_EN is defined, otherwise the
// rotate-every-cycle behaviour.
module tb_rr_arbiter_n;

`ifdef RR_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       nw;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    rr_arbiter_n_if #(.N(4)) bus ();

    rr_arbiter_n #(.N(4), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] g, input logic nw);
        chk({nm, ".gnt"},     32'(bus.gnt),     32'(g));
        chk({nm, ".gnt_id"},  32'(bus.gnt_id),  32'(idx_of(g)));
        chk({nm, ".gnt_vld"}, 32'(bus.gnt_vld), 32'(|g));
        chk({nm, ".gnt_new"}, 32'(bus.gnt_new), 32'(nw));
    endtask

    task automatic add(input logic [3:0] r, input logic [3:0] g, input logic n);
        vec_t v;
        v.req = r;
        v.gnt = g;
        v.nw  = n;
        vecs.push_back(v);
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b0;
        total   = 0;
        bad     = 0;
        bus.req = 4'b1111;

        // all requesters, forced rotation / per-cycle rotation
        for (int c = 0; c < 17; c++) begin
            if (LOCK) add(4'b1111, 4'(1 << ((c / 4) % 4)), (c % 4) == 0);
            else      add(4'b1111, 4'(1 << (c % 4)), 1'b1);
        end
        add(4'b0000, 4'b0000, 1'b0);
        // single requester
        for (int c = 0; c < 10; c++) add(4'b0100, 4'b0100, c == 0);
        add(4'b0000, 4'b0000, 1'b0);
        // early release hand-off
        add(4'b0010, 4'b0010, 1'b1);
        add(4'b1010, LOCK ? 4'b0010 : 4'b1000, !LOCK);
        add(4'b1000, 4'b1000, LOCK);
        add(4'b1000, 4'b1000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0);
        // lone owner saturates, then contention rotates immediately
        for (int c = 0; c < 6; c++) add(4'b0001, 4'b0001, c == 0);
        if (LOCK) begin
            add(4'b0011, 4'b0010, 1'b1);
            add(4'b0011, 4'b0010, 1'b0);
            add(4'b0011, 4'b0010, 1'b0);
            add(4'b0011, 4'b0010, 1'b0);
            add(4'b0011, 4'b0001, 1'b1);
        end else begin
            add(4'b0011, 4'b0010, 1'b1);
            add(4'b0011, 4'b0001, 1'b1);
            add(4'b0011, 4'b0010, 1'b1);
            add(4'b0011, 4'b0001, 1'b1);
            add(4'b0011, 4'b0010, 1'b1);
        end
        add(4'b0000, 4'b0000, 1'b0);

        // reset held with all requesting across edges
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 1'b0);

        @(negedge clk);
        rst     = 1'b1;
        bus.req = vecs[0].req;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) begin
                @(negedge clk);
                bus.req = vecs[i].req;
            end
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].nw);
        end

        // async reset while requester 2 owns the grant
        @(negedge clk);
        bus.req = 4'b0100;
        @(posedge clk);
        #1;
        chk_all("pre_rst", 4'b0100, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_clr", 4'b0000, 1'b0);
        @(negedge clk);
        bus.req = 4'b0110;
        @(posedge clk);
        #1;
        chk_all("in_rst", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 4'b0010, 1'b1);

        // reset while owner 1 (pointer at 2) must restart search at 0
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_clr2", 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("ptr_lost", 4'b0010, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
